// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 shift window,
// emitting one complete neighbourhood per accepted pixel once x>=2 and y>=2.
module conv_window_gen #(
    parameter int DATA_W = 17,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_in,
    output logic [DATA_W-1:0] subimage0,
    output logic [DATA_W-1:0] subimage1,
    output logic [DATA_W-1:0] subimage2,
    output logic [DATA_W-1:0] subimage3,
    output logic [DATA_W-1:0] subimage4,
    output logic [DATA_W-1:0] subimage5,
    output logic [DATA_W-1:0] subimage6,
    output logic [DATA_W-1:0] subimage7,
    output logic [DATA_W-1:0] subimage8,
    output logic              win_valid,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] win [9];
    logic              accept;
    logic [DATA_W-1:0] top_new;
    logic [DATA_W-1:0] mid_new;

    // Reset wins over a pixel presented in the same cycle.
    assign accept  = en && pix_valid && !rst;
    assign top_new = lb1[col];
    assign mid_new = lb0[col];

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_ONE;
            end else begin
                col <= col + COL_ONE;
            end
        end
    end

    // Line buffers are left uncleared; stale contents are masked by win_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= accept && (col >= COL_MIN) && (row >= ROW_MIN);
            frame_done <= accept && (col == COL_LAST) && (row == ROW_LAST);
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[3*r]   <= win[3*r+1];
                    win[3*r+1] <= win[3*r+2];
                end
                win[2] <= top_new;
                win[5] <= mid_new;
                win[8] <= pix_in;
            end
        end
    end

    assign subimage0 = win[0];
    assign subimage1 = win[1];
    assign subimage2 = win[2];
    assign subimage3 = win[3];
    assign subimage4 = win[4];
    assign subimage5 = win[5];
    assign subimage6 = win[6];
    assign subimage7 = win[7];
    assign subimage8 = win[8];

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a 4x4 instance for the small scenarios and a
// default 8x8 instance for the full-frame sweep.
module tb_conv_window_gen;

    localparam int DW = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          en4, pv4, en8, pv8;
    logic [DW-1:0] pix4, pix8;
    logic [DW-1:0] s4 [9];
    logic [DW-1:0] s8 [9];
    logic          wv4, fd4, wv8, fd8;

    int checks   = 0;
    int failures = 0;

    conv_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .pix_valid(pv4), .pix_in(pix4),
        .subimage0(s4[0]), .subimage1(s4[1]), .subimage2(s4[2]),
        .subimage3(s4[3]), .subimage4(s4[4]), .subimage5(s4[5]),
        .subimage6(s4[6]), .subimage7(s4[7]), .subimage8(s4[8]),
        .win_valid(wv4), .frame_done(fd4)
    );

    conv_window_gen #(.DATA_W(DW), .IMG_W(8), .IMG_H(8)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .pix_valid(pv8), .pix_in(pix8),
        .subimage0(s8[0]), .subimage1(s8[1]), .subimage2(s8[2]),
        .subimage3(s8[3]), .subimage4(s8[4]), .subimage5(s8[5]),
        .subimage6(s8[6]), .subimage7(s8[7]), .subimage8(s8[8]),
        .win_valid(wv8), .frame_done(fd8)
    );

    localparam logic [9*DW-1:0] FIRST_WIN =
        {17'd11, 17'd10, 17'd9, 17'd7, 17'd6, 17'd5, 17'd3, 17'd2, 17'd1};
    localparam logic [9*DW-1:0] LAST_WIN =
        {17'd16, 17'd15, 17'd14, 17'd12, 17'd11, 17'd10, 17'd8, 17'd7, 17'd6};

    function automatic logic [9*DW-1:0] pack4();
        return {s4[8], s4[7], s4[6], s4[5], s4[4], s4[3], s4[2], s4[1], s4[0]};
    endfunction

    function automatic logic [9*DW-1:0] pack8();
        return {s8[8], s8[7], s8[6], s8[5], s8[4], s8[3], s8[2], s8[1], s8[0]};
    endfunction

    // Window ending at (x,y) of a frame whose pixel at index i is base+i+1.
    function automatic logic [9*DW-1:0] exp_win(input int w, input int base, input int x, input int y);
        logic [9*DW-1:0] v;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[(3*r+c)*DW +: DW] = DW'(base + w*(y-2+r) + (x-2+c) + 1);
        return v;
    endfunction

    task automatic push4(input logic e, input logic v, input logic [DW-1:0] p);
        en4 = e; pv4 = v; pix4 = p;
        @(posedge clk); #1;
        en4 = 1'b0; pv4 = 1'b0;
    endtask

    task automatic push8(input logic e, input logic v, input logic [DW-1:0] p);
        en8 = e; pv8 = v; pix8 = p;
        @(posedge clk); #1;
        en8 = 1'b0; pv8 = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        checks++; if (wv4 !== 1'b0) begin failures++; $display("FAIL reset_wv4 got=%b exp=0", wv4); end
        checks++; if (fd4 !== 1'b0) begin failures++; $display("FAIL reset_fd4 got=%b exp=0", fd4); end
        checks++; if (pack4() !== '0) begin failures++; $display("FAIL reset_win4 got=%h exp=0", pack4()); end
        checks++; if (wv8 !== 1'b0 || fd8 !== 1'b0) begin failures++; $display("FAIL reset_strobes8 got=%b%b exp=00", wv8, fd8); end
        checks++; if (pack8() !== '0) begin failures++; $display("FAIL reset_win8 got=%h exp=0", pack8()); end
    endtask

    // One continuous 4x4 frame with pixel index i carrying base+i+1.
    task automatic test_frame4(input int base, input string tag);
        int x, y, nstrobe;
        logic ev, ef;
        nstrobe = 0;
        for (int i = 0; i < 16; i++) begin
            push4(1'b1, 1'b1, DW'(base + i + 1));
            x = i % 4; y = i / 4;
            ev = (x >= 2) && (y >= 2);
            ef = (i == 15);
            checks++; if (wv4 !== ev) begin failures++; $display("FAIL %s win_valid idx=%0d got=%b exp=%b", tag, i, wv4, ev); end
            checks++; if (fd4 !== ef) begin failures++; $display("FAIL %s frame_done idx=%0d got=%b exp=%b", tag, i, fd4, ef); end
            if (ev) begin
                nstrobe++;
                checks++;
                if (pack4() !== exp_win(4, base, x, y)) begin
                    failures++; $display("FAIL %s window idx=%0d got=%h exp=%h", tag, i, pack4(), exp_win(4, base, x, y));
                end
            end
            if (base == 0 && i == 10) begin
                checks++; if (pack4() !== FIRST_WIN) begin failures++; $display("FAIL %s first_window got=%h exp=%h", tag, pack4(), FIRST_WIN); end
            end
            if (base == 0 && i == 15) begin
                checks++; if (pack4() !== LAST_WIN) begin failures++; $display("FAIL %s last_window got=%h exp=%h", tag, pack4(), LAST_WIN); end
            end
        end
        checks++; if (nstrobe != 4) begin failures++; $display("FAIL %s strobe_count got=%0d exp=4", tag, nstrobe); end
    endtask

    task automatic test_basic_stream();
        pulse_reset();
        test_frame4(0, "basic");
    endtask

    task automatic test_stall();
        int x, y;
        logic ev;
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            push4(1'b1, 1'b1, DW'(i + 1));
            x = i % 4; y = i / 4;
            ev = (x >= 2) && (y >= 2);
            checks++; if (wv4 !== ev) begin failures++; $display("FAIL stall win_valid idx=%0d got=%b exp=%b", i, wv4, ev); end
            checks++; if (fd4 !== (i == 15)) begin failures++; $display("FAIL stall frame_done idx=%0d got=%b", i, fd4); end
            if (ev) begin
                checks++;
                if (pack4() !== exp_win(4, 0, x, y)) begin
                    failures++; $display("FAIL stall window idx=%0d got=%h exp=%h", i, pack4(), exp_win(4, 0, x, y));
                end
            end
            if (i == 9) begin
                for (int k = 0; k < 3; k++) begin
                    push4(1'b1, 1'b0, DW'(777));
                    checks++; if (wv4 !== 1'b0 || fd4 !== 1'b0) begin failures++; $display("FAIL stall pv_gap_strobe k=%0d got=%b%b exp=00", k, wv4, fd4); end
                end
            end
            if (i == 10) begin
                for (int k = 0; k < 2; k++) begin
                    push4(1'b0, 1'b1, DW'(999));
                    checks++; if (wv4 !== 1'b0 || fd4 !== 1'b0) begin failures++; $display("FAIL stall en_gap_strobe k=%0d got=%b%b exp=00", k, wv4, fd4); end
                    checks++; if (pack4() !== FIRST_WIN) begin failures++; $display("FAIL stall en_gap_hold k=%0d got=%h exp=%h", k, pack4(), FIRST_WIN); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        test_frame4(0, "b2b_f1");
        test_frame4(100, "b2b_f2");
    endtask

    task automatic test_reset_mid_frame();
        pulse_reset();
        for (int i = 0; i < 7; i++) push4(1'b1, 1'b1, DW'(i + 1));
        pulse_reset();
        checks++; if (wv4 !== 1'b0 || fd4 !== 1'b0) begin failures++; $display("FAIL midrst_strobes got=%b%b exp=00", wv4, fd4); end
        checks++; if (pack4() !== '0) begin failures++; $display("FAIL midrst_window got=%h exp=0", pack4()); end
        test_frame4(0, "midrst");
    endtask

    task automatic test_rst_priority();
        pulse_reset();
        push4(1'b1, 1'b1, DW'(5));
        rst = 1'b1; en4 = 1'b1; pv4 = 1'b1; pix4 = DW'(55);
        @(posedge clk); #1;
        rst = 1'b0; en4 = 1'b0; pv4 = 1'b0;
        checks++; if (pack4() !== '0) begin failures++; $display("FAIL rstprio_window got=%h exp=0", pack4()); end
        checks++; if (wv4 !== 1'b0) begin failures++; $display("FAIL rstprio_wv got=%b exp=0", wv4); end
        test_frame4(0, "rstprio");
    endtask

    task automatic test_frame8();
        int x, y, nstrobe;
        logic ev;
        nstrobe = 0;
        pulse_reset();
        for (int i = 0; i < 64; i++) begin
            push8(1'b1, 1'b1, DW'(i + 1));
            x = i % 8; y = i / 8;
            ev = (x >= 2) && (y >= 2);
            if (wv8) nstrobe++;
            checks++; if (wv8 !== ev) begin failures++; $display("FAIL frame8 win_valid idx=%0d got=%b exp=%b", i, wv8, ev); end
            if (ev) begin
                checks++;
                if (pack8() !== exp_win(8, 0, x, y)) begin
                    failures++; $display("FAIL frame8 window idx=%0d got=%h exp=%h", i, pack8(), exp_win(8, 0, x, y));
                end
            end
            checks++; if (fd8 !== (i == 63)) begin failures++; $display("FAIL frame8 frame_done idx=%0d got=%b", i, fd8); end
        end
        checks++; if (nstrobe != 36) begin failures++; $display("FAIL frame8 strobe_count got=%0d exp=36", nstrobe); end
    endtask

    initial begin
        rst = 1'b0;
        en4 = 1'b0; pv4 = 1'b0; pix4 = '0;
        en8 = 1'b0; pv8 = 1'b0; pix8 = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic_stream();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_rst_priority();
        test_frame8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 sliding-window generator that feeds the convolution multiply-accumulate stage. It accepts one raster-order image pixel per cycle, buffers the two previous image rows, and presents the nine pixels of each complete 3x3 neighbourhood on `subimage0`..`subimage8` with a `win_valid` strobe. It sits between the image source and the `muladd` datapath, producing the `subimage*` operands that `muladd` consumes.

## Interface
- `DATA_W`, 17: pixel width in bits; matches the `muladd` operand width.
- `IMG_W`, 8: image width in pixels, ≥3.
- `IMG_H`, 8: image height in pixels, ≥3.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  block enable; when 0, all state is frozen and `pix_valid` is ignored.
- `pix_valid`  in  1  `pix_in` carries a valid pixel this cycle.
- `pix_in`  in  DATA_W  raster-order pixel: row-major, left to right, top to bottom.
- `subimage0`..`subimage8`  out  DATA_W each  window pixel `subimage[3*r+c]`. Row r=0 is the oldest row, y-2. Column c=0 is the oldest column, x-2.
- `win_valid`  out  1  one-cycle strobe: the `subimage*` outputs hold a complete window.
- `frame_done`  out  1  one-cycle strobe: the last pixel of the frame was accepted.

## Operation
- A pixel is accepted when `en=1` and `pix_valid=1`. There is no backpressure; the source must not present pixels faster than one per cycle.
- Position counters:
  - `col` counts 0..IMG_W-1. `row` counts 0..IMG_H-1.
  - On each accepted pixel, `col` increments. When `col=IMG_W-1`, `col` wraps to 0 and `row` increments.
  - At (IMG_W-1, IMG_H-1), both counters wrap to 0 and the next frame begins immediately.
- Line buffers:
  - Two buffers, `lb0` (row y-1) and `lb1` (row y-2), each IMG_W × DATA_W, indexed by `col`.
  - On acceptance: read `lb1[col]` and `lb0[col]` as the old values, then write `lb1[col] <= lb0[col]` and `lb0[col] <= pix_in`.
- Window registers (3×3):
  - On acceptance, each window row shifts left by one column.
  - The new right column gets: top = `lb1[col]`, middle = `lb0[col]`, bottom = `pix_in`.
- Window validity:
  - `win_valid` is set on the cycle after accepting the pixel at (x, y) when x≥2 and y≥2; otherwise it is 0.
  - Windows that straddle a row wrap (x<2) contain stale columns and are never flagged.
  - Rows 0–1 of each frame never produce windows, even though the line buffers hold data from the previous frame.
- Windows per frame: (IMG_W-2)·(IMG_H-2).
- Stall (`pix_valid=0` or `en=0`):
  - Counters, buffers and window registers hold.
  - `subimage*` keep their last values.
  - `win_valid` and `frame_done` are 0.
- `frame_done` is set on the cycle after the pixel at (IMG_W-1, IMG_H-1) is accepted. It coincides with the final `win_valid`.
- Reset: `row`, `col`, window registers, `subimage*`, `win_valid` and `frame_done` all go to 0. Line-buffer contents need not be cleared, because validity masking covers them.

## Timing
- Latency is 1 cycle: `subimage*` and `win_valid` are registered and update on the edge that accepts the pixel.
- Throughput is 1 window per cycle in steady state within a row.
- The outputs are stable from one accepting edge to the next, so `muladd` samples them when `win_valid=1`.
- Reset mid-frame:
  - The next accepted pixel is treated as (0,0).
  - The first window appears only after 2·IMG_W+3 further accepted pixels.
- `rst` has priority over `en` and `pix_valid` in the same cycle.
- Back-to-back frames: the pixel after (IMG_W-1, IMG_H-1) is (0,0) of the new frame. Streaming does not need to pause.

## Test plan
- IMG_W=IMG_H=4, pixels 1..16 streamed continuously:
  - 4 `win_valid` strobes, after pixels 11, 12, 15 and 16.
  - First window = 1,2,3,5,6,7,9,10,11.
  - Last window = 6,7,8,10,11,12,14,15,16, with `frame_done=1` on the same cycle.
- Same stream with `pix_valid` dropped for 3 cycles after pixel 10 and `en` dropped for 2 cycles after pixel 11:
  - Identical window values.
  - No strobes during the gaps.
  - `subimage*` hold 1,2,3,5,6,7,9,10,11 while stalled.
- Two frames back-to-back, second frame pixels 101..116:
  - Second frame's first window = 101,102,103,105,106,107,109,110,111.
  - No strobe is produced on the rows 0–1 of frame 2.
- `rst` pulsed after pixel 7, then pixels 1..16 streamed:
  - All outputs 0 the cycle after reset.
  - Results match the first scenario exactly.
- Default 8×8 frame with pixel = index+1:
  - Exactly 36 strobes.
  - Each window satisfies `subimage[3r+c]` = 8·(y-2+r)+(x-2+c)+1.
- `rst` and `pix_valid` asserted together: pixel not accepted, counters remain at (0,0).
